// File: rtl/ifetch_queue.sv
// ifetch_queue: fetch PC owner, in-order memory request issue and response FIFO
// feeding decode through a valid/ready handshake. A redirect flushes the queue
// and arranges for in-flight responses to be discarded.
// Optional build macro: IFQ_BYPASS_EN. When it is defined, a response arriving
// while the queue is empty is shown to decode in the same cycle.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic [31:0]   resp_pc, resp_pc_nxt;
  logic [PW-1:0] rd_ptr, rd_ptr_nxt;
  logic [PW-1:0] wr_ptr, wr_ptr_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [CW-1:0] outstanding, outstanding_nxt;
  logic [CW-1:0] discard, discard_nxt;
  logic [CW-1:0] outstanding_upd;
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem [DEPTH];
  logic [31:0]   target;
  logic          credit_ok, accept, rsp, keep, push, pop, head_valid;

  // Word-aligned redirect target.
  assign target = redirect_pc_i & ~32'h0000_0003;

  // Queued entries plus in-flight requests never exceed DEPTH.
  assign credit_ok  = ({1'b0, count} + {1'b0, outstanding}) < SW'(DEPTH);
  assign mem_req_o  = !reset && !redirect_i && credit_ok;
  assign mem_addr_o = fetch_pc;

  // Handshake qualifiers; responses with nothing outstanding are ignored.
  assign accept     = mem_req_o && mem_gnt_i;
  assign rsp        = mem_rvalid_i && (outstanding != '0);
  assign keep       = rsp && (discard == '0) && !redirect_i;
  assign head_valid = (count != '0);
  assign pop        = head_valid && instr_ready_i && !redirect_i;

`ifdef IFQ_BYPASS_EN
  logic bypass;

  // Empty queue: forward the response straight to decode.
  assign bypass = keep && !head_valid;
  assign push   = keep && !(bypass && instr_ready_i);

  // Decode-facing outputs: FIFO head, else bypassed response, else NOP.
  always_comb begin
    instr_valid_o = head_valid || bypass;
    instr_o       = NOP;
    instr_pc_o    = 32'h0;
    if (head_valid) begin
      instr_o    = instr_mem[rd_ptr];
      instr_pc_o = pc_mem[rd_ptr];
    end else if (bypass) begin
      instr_o    = mem_rdata_i;
      instr_pc_o = resp_pc;
    end
  end
`else
  assign push = keep;

  // Decode-facing outputs come only from the FIFO head.
  always_comb begin
    instr_valid_o = head_valid;
    instr_o       = NOP;
    instr_pc_o    = 32'h0;
    if (head_valid) begin
      instr_o    = instr_mem[rd_ptr];
      instr_pc_o = pc_mem[rd_ptr];
    end
  end
`endif

  assign outstanding_upd = outstanding + CW'(accept) - CW'(rsp);

  // Next-state logic; redirect overrides every other update.
  always_comb begin
    fetch_pc_nxt    = fetch_pc;
    resp_pc_nxt     = resp_pc;
    rd_ptr_nxt      = rd_ptr;
    wr_ptr_nxt      = wr_ptr;
    count_nxt       = count;
    outstanding_nxt = outstanding_upd;
    discard_nxt     = discard;
    if (redirect_i) begin
      fetch_pc_nxt = target;
      resp_pc_nxt  = target;
      rd_ptr_nxt   = '0;
      wr_ptr_nxt   = '0;
      count_nxt    = '0;
      discard_nxt  = outstanding_upd;
    end else begin
      if (accept) fetch_pc_nxt = fetch_pc + 32'd4;
      if (keep)   resp_pc_nxt  = resp_pc + 32'd4;
      if (push)   wr_ptr_nxt   = wr_ptr + PW'(1);
      if (pop)    rd_ptr_nxt   = rd_ptr + PW'(1);
      count_nxt = count + CW'(push) - CW'(pop);
      if (rsp && (discard != '0)) discard_nxt = discard - CW'(1);
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      fetch_pc    <= fetch_pc_nxt;
      resp_pc     <= resp_pc_nxt;
      rd_ptr      <= rd_ptr_nxt;
      wr_ptr      <= wr_ptr_nxt;
      count       <= count_nxt;
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
    end
  end

  // FIFO storage; contents are qualified by count so need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= mem_rdata_i;
      pc_mem[wr_ptr]    <= resp_pc;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: in-order memory responder with programmable
// latency plus a linear sequence of hand-computed checks.
module tb_ifetch_queue;

  logic        clk;
  logic        reset;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned lat   = 1;
  int unsigned cyc   = 0;
  logic        unsol = 1'b0;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } pend_t;
  pend_t pq[$];

  ifetch_queue dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction word stored at a given address in the memory model.
  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to the drive point of the next cycle.
  task automatic next();
    @(posedge clk);
    #2;
  endtask

  // Hold reset for two edges and release it; the caller is then in cycle 0.
  task automatic restart();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // In-order memory: responses at posedge+1, grants captured at negedge.
  initial begin
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
        pq.delete();
        mem_rvalid_i = 1'b0;
      end else if (pq.size() > 0 && pq[0].due <= cyc) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = word(pq[0].addr);
        void'(pq.pop_front());
      end else if (unsol) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEAD_BEEF;
      end else begin
        mem_rvalid_i = 1'b0;
      end
      @(negedge clk);
      if (!reset && mem_req_o && mem_gnt_i)
        pq.push_back('{addr: mem_addr_o, due: cyc + lat});
    end
  end

  initial begin
    reset = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    mem_gnt_i = 1'b1; instr_ready_i = 1'b1; lat = 1;
    #1;
    chk1 ("rst_req",   mem_req_o,     1'b0);
    chk32("rst_addr",  mem_addr_o,    32'h0);
    chk1 ("rst_valid", instr_valid_o, 1'b0);
    chk32("rst_instr", instr_o,       32'h0000_0013);
    chk32("rst_pc",    instr_pc_o,    32'h0);

    // Streaming with 1-cycle memory and ready high.
    restart();
    @(negedge clk);
    chk1 ("s0_req",   mem_req_o,     1'b1);
    chk32("s0_addr",  mem_addr_o,    32'h0);
    chk1 ("s0_valid", instr_valid_o, 1'b0);
    next(); @(negedge clk);
    chk32("s1_addr",  mem_addr_o,    32'h4);
    chk1 ("s1_valid", instr_valid_o, 1'b0);
    for (int k = 2; k <= 9; k++) begin
      next(); @(negedge clk);
      chk1 ("s_valid", instr_valid_o, 1'b1);
      chk32("s_pc",    instr_pc_o,    32'(4 * (k - 2)));
      chk32("s_instr", instr_o,       word(32'(4 * (k - 2))));
    end

    // Decode stall: queue fills and requests stop.
    next(); instr_ready_i = 1'b0; @(negedge clk);
    chk32("st10_pc", instr_pc_o, 32'h20);
    for (int k = 11; k <= 19; k++) begin
      next(); @(negedge clk);
      chk1 ("st_valid", instr_valid_o, 1'b1);
      chk32("st_pc",    instr_pc_o,    32'h20);
      if (k >= 12) chk1("st_req", mem_req_o, 1'b0);
    end
    // Drain in order without loss or duplication.
    next(); instr_ready_i = 1'b1; @(negedge clk);
    chk32("d20_pc", instr_pc_o, 32'h20);
    for (int k = 21; k <= 27; k++) begin
      next(); @(negedge clk);
      chk1 ("d_valid", instr_valid_o, 1'b1);
      chk32("d_pc",    instr_pc_o,    32'(32 + 4 * (k - 20)));
      chk32("d_instr", instr_o,       word(32'(32 + 4 * (k - 20))));
      if (k == 21) chk32("d21_addr", mem_addr_o, 32'h30);
    end

    // Latency 3, redirect with two requests in flight.
    lat = 3;
    restart();
    next();
    next(); redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103; @(negedge clk);
    chk1 ("r2_req", mem_req_o, 1'b0);
    next(); redirect_i = 1'b0; @(negedge clk);
    chk1 ("r3_req",   mem_req_o,     1'b1);
    chk32("r3_addr",  mem_addr_o,    32'h100);
    chk1 ("r3_valid", instr_valid_o, 1'b0);
    next(); @(negedge clk);
    chk32("r4_addr",  mem_addr_o,    32'h104);
    chk1 ("r4_valid", instr_valid_o, 1'b0);
    next(); @(negedge clk);
    chk1 ("r5_valid", instr_valid_o, 1'b0);
    next(); @(negedge clk);
    chk1 ("r6_valid", instr_valid_o, 1'b0);
    next(); @(negedge clk);
    chk1 ("r7_valid", instr_valid_o, 1'b1);
    chk32("r7_pc",    instr_pc_o,    32'h100);
    chk32("r7_instr", instr_o,       word(32'h100));
    next(); @(negedge clk);
    chk32("r8_pc",    instr_pc_o,    32'h104);

    // Redirect coinciding with the only outstanding response.
    lat = 2; mem_gnt_i = 1'b1;
    restart();
    @(negedge clk);
    chk32("c0_addr", mem_addr_o, 32'h0);
    next(); mem_gnt_i = 1'b0; @(negedge clk);
    chk1 ("c1_req",  mem_req_o,  1'b1);
    chk32("c1_addr", mem_addr_o, 32'h4);
    next(); redirect_i = 1'b1; redirect_pc_i = 32'h200; @(negedge clk);
    chk1 ("c2_rv",  mem_rvalid_i, 1'b1);
    chk1 ("c2_req", mem_req_o,    1'b0);
    next(); redirect_i = 1'b0; mem_gnt_i = 1'b1; @(negedge clk);
    chk32("c3_addr",  mem_addr_o,    32'h200);
    chk1 ("c3_valid", instr_valid_o, 1'b0);
    next(); @(negedge clk);
    chk32("c4_addr",  mem_addr_o,    32'h204);
    chk1 ("c4_valid", instr_valid_o, 1'b0);
    next(); @(negedge clk);
    chk1 ("c5_valid", instr_valid_o, 1'b0);
    next(); @(negedge clk);
    chk1 ("c6_valid", instr_valid_o, 1'b1);
    chk32("c6_pc",    instr_pc_o,    32'h200);
    chk32("c6_instr", instr_o,       word(32'h200));

    // Grant withheld: address stable; unsolicited response ignored; redirect.
    lat = 1; mem_gnt_i = 1'b0;
    restart();
    @(negedge clk);
    chk1 ("g0_req",  mem_req_o,  1'b1);
    chk32("g0_addr", mem_addr_o, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      next();
      unsol = (k == 1);
      @(negedge clk);
      chk1 ("g_req",   mem_req_o,     1'b1);
      chk32("g_addr",  mem_addr_o,    32'h0);
      if (k >= 3) chk1("g_unsol_valid", instr_valid_o, 1'b0);
    end
    next(); redirect_i = 1'b1; redirect_pc_i = 32'h40; @(negedge clk);
    chk1 ("g5_req", mem_req_o, 1'b0);
    next(); redirect_i = 1'b0; mem_gnt_i = 1'b1; @(negedge clk);
    chk1 ("g6_req",  mem_req_o,  1'b1);
    chk32("g6_addr", mem_addr_o, 32'h40);
    next(); @(negedge clk);
    chk1 ("g7_valid", instr_valid_o, 1'b0);
    next(); @(negedge clk);
    chk1 ("g8_valid", instr_valid_o, 1'b1);
    chk32("g8_pc",    instr_pc_o,    32'h40);

    // Reset with three queued entries clears outputs immediately.
    instr_ready_i = 1'b0;
    restart();
    repeat (4) next();
    @(negedge clk);
    chk1 ("f4_valid", instr_valid_o, 1'b1);
    chk32("f4_pc",    instr_pc_o,    32'h0);
    chk1 ("f4_req",   mem_req_o,     1'b0);
    chk32("f4_addr",  mem_addr_o,    32'h10);
    #1 reset = 1'b1;
    #1;
    chk1 ("ar_valid", instr_valid_o, 1'b0);
    chk32("ar_addr",  mem_addr_o,    32'h0);
    chk1 ("ar_req",   mem_req_o,     1'b0);
    chk32("ar_instr", instr_o,       32'h0000_0013);
    chk32("ar_pc",    instr_pc_o,    32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
